// File: rtl/payload_chain_engine.sv
// payload_chain_engine: streaming chain matcher over decoded byte classes.
// Tracks a linear pattern with optional zero-or-more elements, counts matches.
module payload_chain_engine #(
    parameter int                      N_STATES  = 19,
    parameter int                      N_CHARS   = 128,
    parameter logic [N_STATES*7-1:0]   SEL       = '0,
    parameter logic [N_STATES-1:0]     STAR_MASK = '0,
    parameter bit                      ANCHORED  = 1'b0,
    parameter int                      OFF_W     = 16
) (
    input  logic               clk,
    input  logic               sod,
    input  logic               en,
    input  logic [N_CHARS-1:0] in_char,
    output logic               match,
    output logic               match_pulse,
    output logic [OFF_W-1:0]   match_offset,
    output logic [OFF_W-1:0]   match_count
);

    logic [N_STATES-1:0] a;
    logic [N_STATES-1:0] a_nxt;
    logic [OFF_W-1:0]    byte_cnt;
    logic [127:0]        ext;
    logic                start_tok;
    logic                hit;

    // Present a fixed 128-bit class view so 7-bit selectors index it directly.
    if (N_CHARS >= 128) begin : g_trunc
        assign ext = in_char[127:0];
    end else begin : g_pad
        assign ext = {{(128-N_CHARS){1'b0}}, in_char};
    end

    assign start_tok = ANCHORED ? (byte_cnt == '0) : 1'b1;

    // Next-state chain; pv carries the predecessor enable so runs of stars bypass.
    always_comb begin
        logic pv;
        a_nxt = '0;
        pv    = start_tok;
        for (int i = 0; i < N_STATES; i++) begin
            a_nxt[i] = ext[SEL[i*7 +: 7]] & (pv | (STAR_MASK[i] & a[i]));
            pv       = a[i] | (STAR_MASK[i] & pv);
        end
    end

    assign hit = a_nxt[N_STATES-1];

    // State vector and saturating byte position advance only on valid bytes.
    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            a        <= '0;
            byte_cnt <= '0;
        end else if (en) begin
            a <= a_nxt;
            if (byte_cnt != '1)
                byte_cnt <= byte_cnt + OFF_W'(1);
        end
    end

    // Pulse follows each completing byte only; idle cycles force it low.
    always_ff @(posedge clk or posedge sod) begin
        if (sod)
            match_pulse <= 1'b0;
        else
            match_pulse <= en & hit;
    end

    // Sticky flag, first-hit offset and saturating match count.
    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            match        <= 1'b0;
            match_offset <= '0;
            match_count  <= '0;
        end else if (en && hit) begin
            match <= 1'b1;
            if (!match)
                match_offset <= byte_cnt;
            if (match_count != '1)
                match_count <= match_count + OFF_W'(1);
        end
    end

endmodule
